// File: rtl/tmds_deser_1to10.sv
// Single-lane 1:10 DDR deserializer: rebuilds 10-bit words from IDDR bit pairs,
// aligns on a comma token and reports lock.
module tmds_deser_1to10 #(
    parameter logic [9:0]  COMMA        = 10'b1101010100,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned LOSS_TIMEOUT = 1024
) (
    input  logic       clkx5,
    input  logic       rst_n,
    input  logic       din_rise,
    input  logic       din_fall,
    output logic [9:0] dataout,
    output logic       dataout_valid,
    output logic       locked,
    output logic [3:0] align_offset
);

    localparam logic [1:0]  StSearch    = 2'd0;
    localparam logic [1:0]  StVerify    = 2'd1;
    localparam logic [1:0]  StLocked    = 2'd2;
    localparam logic [3:0]  LockCnt     = 4'(LOCK_COUNT);
    localparam logic [15:0] TimeoutLast = 16'(LOSS_TIMEOUT - 1);

    // Windows reach back at most 19 bits, so older history is never kept.
    logic [16:0] hist_q;
    logic [18:0] hist_next;
    logic [2:0]  cnt5_q, cnt5_d;
    logic        word_edge;

    logic [9:0]  win_word [10];
    logic [9:0]  cur_word;
    logic        cur_comma;
    logic        any_comma;
    logic [3:0]  first_off;

    logic [1:0]  state_q, state_d;
    logic [3:0]  match_q, match_d;
    logic [15:0] timeout_q, timeout_d;
    logic [9:0]  dataout_q, dataout_d;
    logic        valid_q, valid_d;
    logic        locked_q, locked_d;
    logic [3:0]  offset_q, offset_d;

    assign hist_next = {hist_q, din_rise, din_fall};
    assign word_edge = (cnt5_q == 3'd4);

    // Serial order per pair is odd bit then even bit, so swap within each pair.
    always_comb begin
        for (int o = 0; o < 10; o++) begin
            for (int i = 0; i < 10; i++) begin
                if (i % 2 == 1) begin
                    win_word[o][i] = hist_next[10 + o - i];
                end else begin
                    win_word[o][i] = hist_next[8 + o - i];
                end
            end
        end
    end

    always_comb begin
        any_comma = 1'b0;
        first_off = 4'd0;
        for (int o = 9; o >= 0; o--) begin
            if (win_word[o] == COMMA) begin
                any_comma = 1'b1;
                first_off = 4'(o);
            end
        end
        cur_word = 10'd0;
        for (int o = 0; o < 10; o++) begin
            if (offset_q == 4'(o)) begin
                cur_word = win_word[o];
            end
        end
        cur_comma = (cur_word == COMMA);
    end

    always_comb begin
        cnt5_d    = word_edge ? 3'd0 : cnt5_q + 3'd1;
        state_d   = state_q;
        match_d   = match_q;
        timeout_d = timeout_q;
        dataout_d = dataout_q;
        locked_d  = locked_q;
        offset_d  = offset_q;
        valid_d   = 1'b0;
        if (word_edge) begin
            dataout_d = cur_word;
            case (state_q)
                StSearch: begin
                    if (any_comma) begin
                        offset_d = first_off;
                        match_d  = 4'd1;
                        if (LockCnt == 4'd1) begin
                            state_d   = StLocked;
                            locked_d  = 1'b1;
                            timeout_d = 16'd0;
                        end else begin
                            state_d = StVerify;
                        end
                    end
                end
                StVerify: begin
                    if (cur_comma) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == LockCnt) begin
                            state_d   = StLocked;
                            locked_d  = 1'b1;
                            timeout_d = 16'd0;
                        end
                    end else begin
                        state_d = StSearch;
                        match_d = 4'd0;
                    end
                end
                StLocked: begin
                    if (cur_comma) begin
                        timeout_d = 16'd0;
                    end else if (timeout_q == TimeoutLast) begin
                        state_d   = StSearch;
                        locked_d  = 1'b0;
                        match_d   = 4'd0;
                        timeout_d = 16'd0;
                    end else begin
                        timeout_d = timeout_q + 16'd1;
                    end
                end
                default: begin
                    state_d  = StSearch;
                    locked_d = 1'b0;
                    match_d  = 4'd0;
                end
            endcase
            valid_d = locked_d;
        end
    end

    always_ff @(posedge clkx5 or negedge rst_n) begin
        if (!rst_n) begin
            hist_q    <= '0;
            cnt5_q    <= '0;
            state_q   <= StSearch;
            match_q   <= '0;
            timeout_q <= '0;
            dataout_q <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            offset_q  <= '0;
        end else begin
            hist_q    <= hist_next[16:0];
            cnt5_q    <= cnt5_d;
            state_q   <= state_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            offset_q  <= offset_d;
        end
    end

    assign dataout       = dataout_q;
    assign dataout_valid = valid_q;
    assign locked        = locked_q;
    assign align_offset  = offset_q;

endmodule

// File: tb/tb_tmds_deser_1to10.sv
// Bench for tmds_deser_1to10: serial bit-stream reference model plus directed
// checks of reset, alignment, verify abort, loss of lock and async reset.
module tb_tmds_deser_1to10;

    localparam logic [9:0]  COMMA        = 10'b1101010100;
    localparam int unsigned LOCK_COUNT   = 4;
    localparam int unsigned LOSS_TIMEOUT = 1024;

    localparam int MS_SEARCH = 0;
    localparam int MS_VERIFY = 1;
    localparam int MS_LOCKED = 2;

    logic       clkx5;
    logic       rst_n;
    logic       din_rise;
    logic       din_fall;
    logic [9:0] dataout;
    logic       dataout_valid;
    logic       locked;
    logic [3:0] align_offset;

    tmds_deser_1to10 #(
        .COMMA        (COMMA),
        .LOCK_COUNT   (LOCK_COUNT),
        .LOSS_TIMEOUT (LOSS_TIMEOUT)
    ) dut (
        .clkx5         (clkx5),
        .rst_n         (rst_n),
        .din_rise      (din_rise),
        .din_fall      (din_fall),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .locked        (locked),
        .align_offset  (align_offset)
    );

    initial clkx5 = 1'b0;
    always #5 clkx5 = ~clkx5;

    int checks   = 0;
    int failures = 0;

    // Reference model: every serial bit since reset release, oldest first.
    logic       bits [$];
    logic       txq [$];
    logic [9:0] rxq [$];
    int         n_edges;
    int         m_state;
    int         m_count;
    int         m_miss;
    logic [9:0] m_data;
    logic       m_valid;
    logic       m_locked;
    int         m_off;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic getbit(input int idx);
        if (idx < 0) return 1'b0;
        return bits[idx];
    endfunction

    // Word whose last serial bit lies o bits before the newest one.
    function automatic logic [9:0] word_at(input int o);
        logic [9:0] w;
        int base;
        base = bits.size() - 10 - o;
        for (int k = 0; k < 5; k++) begin
            w[2*k+1] = getbit(base + 2*k);
            w[2*k]   = getbit(base + 2*k + 1);
        end
        return w;
    endfunction

    task automatic model_reset();
        bits.delete();
        n_edges  = 0;
        m_state  = MS_SEARCH;
        m_count  = 0;
        m_miss   = 0;
        m_data   = '0;
        m_valid  = 1'b0;
        m_locked = 1'b0;
        m_off    = 0;
    endtask

    task automatic model_word();
        int found;
        m_data = word_at(m_off);
        if (m_state == MS_SEARCH) begin
            found = -1;
            for (int o = 9; o >= 0; o--) if (word_at(o) == COMMA) found = o;
            if (found >= 0) begin
                m_off   = found;
                m_count = 1;
                m_state = MS_VERIFY;
            end
        end else if (m_state == MS_VERIFY) begin
            if (word_at(m_off) == COMMA) m_count++;
            else begin
                m_count = 0;
                m_state = MS_SEARCH;
            end
        end else begin
            if (word_at(m_off) == COMMA) m_miss = 0;
            else m_miss++;
            if (m_miss >= int'(LOSS_TIMEOUT)) begin
                m_state  = MS_SEARCH;
                m_locked = 1'b0;
                m_count  = 0;
            end
        end
        if (m_state == MS_VERIFY && m_count >= int'(LOCK_COUNT)) begin
            m_state  = MS_LOCKED;
            m_locked = 1'b1;
            m_miss   = 0;
        end
        m_valid = m_locked;
    endtask

    task automatic step(input logic r, input logic f);
        din_rise = r;
        din_fall = f;
        @(posedge clkx5);
        m_valid = 1'b0;
        if (rst_n) begin
            bits.push_back(r);
            bits.push_back(f);
            n_edges++;
            if (n_edges % 5 == 0) model_word();
        end
        @(negedge clkx5);
        chk("model_dataout", 32'(dataout), 32'(m_data));
        chk("model_valid", 32'(dataout_valid), 32'(m_valid));
        chk("model_locked", 32'(locked), 32'(m_locked));
        chk("model_offset", 32'(align_offset), 32'(m_off));
        if (dataout_valid) rxq.push_back(dataout);
    endtask

    task automatic drain();
        logic r, f;
        while (txq.size() >= 2) begin
            r = txq.pop_front();
            f = txq.pop_front();
            step(r, f);
        end
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int k = 0; k < 5; k++) begin
            txq.push_back(w[2*k+1]);
            txq.push_back(w[2*k]);
        end
        drain();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        txq.delete();
        model_reset();
        #1;
        chk("rst_async_valid", 32'(dataout_valid), 32'd0);
        chk("rst_async_locked", 32'(locked), 32'd0);
        chk("rst_async_dataout", 32'(dataout), 32'd0);
        chk("rst_async_offset", 32'(align_offset), 32'd0);
        for (int i = 0; i < n; i++) step(1'($urandom), 1'($urandom));
        rst_n = 1'b1;
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (w == COMMA || w == 10'd0);
        return w;
    endfunction

    initial begin
        logic [9:0] w;
        logic [9:0] got;
        int since;
        rst_n    = 1'b1;
        din_rise = 1'b0;
        din_fall = 1'b0;
        model_reset();
        #1;

        // Reset, then first word edge on the 5th edge after release.
        do_reset(7);
        w = rand_data();
        for (int k = 0; k < 5; k++) begin
            step(w[2*k+1], w[2*k]);
            if (k == 3) chk("first_edge_not_yet", 32'(dataout), 32'd0);
        end
        chk("first_edge_word", 32'(dataout), 32'(w));
        chk("first_edge_no_valid", 32'(dataout_valid), 32'd0);

        // Aligned lock.
        do_reset(3);
        for (int i = 1; i <= 4; i++) begin
            send_word(COMMA);
            chk("aligned_locked", 32'(locked), 32'(i >= int'(LOCK_COUNT)));
        end
        chk("aligned_offset", 32'(align_offset), 32'd0);
        send_word(10'h2A5);
        chk("aligned_data", 32'(dataout), 32'h2A5);
        chk("aligned_valid", 32'(dataout_valid), 32'd1);

        // Shifted lock: three leading bits before the comma stream.
        do_reset(3);
        for (int i = 0; i < 3; i++) txq.push_back(1'b0);
        drain();
        for (int i = 0; i < 6; i++) send_word(COMMA);
        chk("shift_locked", 32'(locked), 32'd1);
        chk("shift_offset", 32'(align_offset), 32'((10 - 3 % 10) % 10));
        rxq.delete();
        send_word(10'h155);
        send_word(10'h3FF);
        send_word(rand_data());
        send_word(rand_data());
        while (rxq.size() > 0 && rxq[0] == COMMA) void'(rxq.pop_front());
        got = (rxq.size() > 0) ? rxq.pop_front() : 10'bx;
        chk("shift_word0", 32'(got), 32'h155);
        got = (rxq.size() > 0) ? rxq.pop_front() : 10'bx;
        chk("shift_word1", 32'(got), 32'h3FF);

        // VERIFY abort.
        do_reset(2);
        send_word(COMMA);
        send_word(COMMA);
        send_word(10'h000);
        chk("abort_locked", 32'(locked), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            send_word(COMMA);
            chk("abort_relock", 32'(locked), 32'(i >= int'(LOCK_COUNT)));
        end

        // Loss of lock after LOSS_TIMEOUT non-comma words.
        for (int n = 1; n <= int'(LOSS_TIMEOUT); n++) begin
            send_word(rand_data());
            if (n >= int'(LOSS_TIMEOUT) - 2) begin
                chk("loss_locked", 32'(locked), 32'(n < int'(LOSS_TIMEOUT)));
                chk("loss_valid", 32'(dataout_valid), 32'(n < int'(LOSS_TIMEOUT)));
            end
        end

        // A comma at word 1000 restarts the timeout.
        do_reset(2);
        for (int i = 0; i < 4; i++) send_word(COMMA);
        since = 0;
        for (int n = 1; n <= 1200; n++) begin
            if (n == 1000) begin
                send_word(COMMA);
                since = 0;
            end else begin
                send_word(rand_data());
                since++;
            end
            if (n % 100 == 0 || n == 1024) begin
                chk("restart_locked", 32'(locked), 32'(since < int'(LOSS_TIMEOUT)));
            end
        end

        // Async reset while locked, just after a valid word.
        send_word(COMMA);
        chk("pre_rst_valid", 32'(dataout_valid), 32'd1);
        do_reset(1);
        for (int i = 1; i <= 4; i++) begin
            send_word(COMMA);
            chk("post_rst_locked", 32'(locked), 32'(i >= int'(LOCK_COUNT)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
